// File: rtl/nexys_rst_gen.sv
// Board reset conditioner for the Nexys SoC: synchronises button and clock-lock,
// sequences the SoC/JTAG resets and records the last reset cause.
// Optional button debounce filter is compiled in with `define NEXYS_RST_DEBOUNCE_EN.
module nexys_rst_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned HOLD_CYCLES     = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_rst_ni,
  input  logic       clk_locked_i,
  output logic       soc_rst_no,
  output logic       jtag_trst_no,
  output logic [1:0] rst_cause_o
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = {HOLD_W{1'b1}};

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_LOCK = 2'b10;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    HOLD      = 2'b01,
    RUN       = 2'b10,
    BTN       = 2'b11
  } state_e;

  // Two-flop synchronisers; button idles released, lock idles unlocked.
  logic btn_meta_q, btn_sync_q;
  logic lock_meta_q, lock_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_meta_q  <= 1'b1;
      btn_sync_q  <= 1'b1;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      btn_meta_q  <= btn_rst_ni;
      btn_sync_q  <= btn_meta_q;
      lock_meta_q <= clk_locked_i;
      lock_sync_q <= lock_meta_q;
    end
  end

  logic btn_db;

`ifdef NEXYS_RST_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_MAX  = {DB_W{1'b1}};

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_db_q, btn_db_d;

  // Accept a new button level only after it has been stable for DEBOUNCE_CYCLES.
  always_comb begin
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    if (btn_sync_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = ~btn_db_q;
      end else if (db_cnt_q != DB_MAX) begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end else begin
        db_cnt_d = db_cnt_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_cnt_q <= '0;
      btn_db_q <= 1'b1;
    end else begin
      db_cnt_q <= db_cnt_d;
      btn_db_q <= btn_db_d;
    end
  end

  assign btn_db = btn_db_q;
`else
  // Filter compiled out: DEBOUNCE_CYCLES is accepted but has no effect.
  if (DEBOUNCE_CYCLES == 0) begin : g_db_unused
  end

  assign btn_db = btn_sync_q;
`endif

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]        cause_q, cause_d;
  logic              soc_rst_q, soc_rst_d;
  logic              jtag_trst_q, jtag_trst_d;

  // Next-state logic; lock loss has priority over the button everywhere.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = '0;
    cause_d     = cause_q;
    soc_rst_d   = 1'b0;
    jtag_trst_d = jtag_trst_q;

    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_sync_q && btn_db) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!lock_sync_q) begin
          state_d = WAIT_LOCK;
        end else if (!btn_db) begin
          state_d = BTN;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      RUN: begin
        if (!lock_sync_q) begin
          state_d = WAIT_LOCK;
          cause_d = CAUSE_LOCK;
        end else if (!btn_db) begin
          state_d = BTN;
          cause_d = CAUSE_BTN;
        end
      end
      BTN: begin
        if (!lock_sync_q) begin
          state_d = WAIT_LOCK;
        end else if (btn_db) begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    // Outputs follow the next state so they update on the same edge as the FSM.
    soc_rst_d = (state_d == RUN);
    if (state_d == RUN) begin
      jtag_trst_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WAIT_LOCK;
      hold_cnt_q  <= '0;
      cause_q     <= CAUSE_POR;
      soc_rst_q   <= 1'b0;
      jtag_trst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cause_q     <= cause_d;
      soc_rst_q   <= soc_rst_d;
      jtag_trst_q <= jtag_trst_d;
    end
  end

  assign soc_rst_no   = soc_rst_q;
  assign jtag_trst_no = jtag_trst_q;
  assign rst_cause_o  = cause_q;

endmodule

// File: tb/tb_nexys_rst_gen.sv
// Directed bench for nexys_rst_gen with DEBOUNCE_CYCLES=8, HOLD_CYCLES=16.
// Expected latencies follow NEXYS_RST_DEBOUNCE_EN as compiled.
module tb_nexys_rst_gen;

  localparam int unsigned DEB  = 8;
  localparam int unsigned HOLD = 16;
`ifdef NEXYS_RST_DEBOUNCE_EN
  localparam int DB_LAT = 2 + DEB;
`else
  localparam int DB_LAT = 2;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       btn_rst_ni;
  logic       clk_locked_i;
  logic       soc_rst_no;
  logic       jtag_trst_no;
  logic [1:0] rst_cause_o;

  int n_vec  = 0;
  int n_miss = 0;

  nexys_rst_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .btn_rst_ni  (btn_rst_ni),
    .clk_locked_i(clk_locked_i),
    .soc_rst_no  (soc_rst_no),
    .jtag_trst_no(jtag_trst_no),
    .rst_cause_o (rst_cause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Count rising edges until soc_rst_no reaches lvl; bounded.
  task automatic wait_soc(input logic lvl, input int start, output int n);
    n = start;
    while (soc_rst_no !== lvl && n < 200) begin
      tick();
      n++;
    end
  endtask

  int n;
  int lows;

  initial begin
    rst_ni       = 1'b0;
    btn_rst_ni   = 1'b1;
    clk_locked_i = 1'b1;

    // Power-on reset
    #1;
    chk("por_soc_in_rst", 32'(soc_rst_no), 32'd0);
    chk("por_jtag_in_rst", 32'(jtag_trst_no), 32'd0);
    chk("por_cause_in_rst", 32'(rst_cause_o), 32'd0);
    repeat (5) tick();
    rst_ni = 1'b1;
    wait_soc(1'b1, 0, n);
    chk("por_rise_edge", 32'(n), 32'd19);
    chk("por_jtag", 32'(jtag_trst_no), 32'd1);
    chk("por_cause", 32'(rst_cause_o), 32'd0);

    // Short glitch on the button
    repeat (3) tick();
    btn_rst_ni = 1'b0;
`ifdef NEXYS_RST_DEBOUNCE_EN
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 5) btn_rst_ni = 1'b1;
      tick();
      if (soc_rst_no !== 1'b1) lows++;
    end
    chk("glitch_soc_lows", 32'(lows), 32'd0);
    chk("glitch_cause", 32'(rst_cause_o), 32'd0);
`else
    repeat (3) tick();
    chk("glitch_soc_low", 32'(soc_rst_no), 32'd0);
    chk("glitch_cause", 32'(rst_cause_o), 32'd1);
    repeat (2) tick();
    btn_rst_ni = 1'b1;
    wait_soc(1'b1, 0, n);
    chk("glitch_rise_edge", 32'(n), 32'd19);
`endif
    chk("glitch_jtag", 32'(jtag_trst_no), 32'd1);

    // Long press
    repeat (3) tick();
    btn_rst_ni = 1'b0;
    wait_soc(1'b0, 0, n);
    chk("press_fall_edge", 32'(n), 32'(DB_LAT + 1));
    chk("press_cause", 32'(rst_cause_o), 32'd1);
    chk("press_jtag", 32'(jtag_trst_no), 32'd1);
    repeat (40 - n) tick();
    btn_rst_ni = 1'b1;
    wait_soc(1'b1, 0, n);
    chk("press_rise_edge", 32'(n), 32'(DB_LAT + 1 + 16));
    chk("press_jtag_after", 32'(jtag_trst_no), 32'd1);

    // Simultaneous lock loss and button press
    repeat (3) tick();
    btn_rst_ni   = 1'b0;
    clk_locked_i = 1'b0;
    repeat (DB_LAT + 3) tick();
    chk("simul_soc", 32'(soc_rst_no), 32'd0);
    chk("simul_cause", 32'(rst_cause_o), 32'd2);
    chk("simul_jtag", 32'(jtag_trst_no), 32'd1);
    btn_rst_ni   = 1'b1;
    clk_locked_i = 1'b1;
    wait_soc(1'b1, 0, n);
    chk("simul_rise_edge", 32'(n), 32'(DB_LAT + 17));
    chk("simul_cause_kept", 32'(rst_cause_o), 32'd2);

    // Asynchronous reset between edges
    repeat (4) tick();
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_soc", 32'(soc_rst_no), 32'd0);
    chk("async_jtag", 32'(jtag_trst_no), 32'd0);
    chk("async_cause", 32'(rst_cause_o), 32'd0);
    repeat (3) tick();

    // Lock drop mid-HOLD at hold count 10 restarts the hold time
    rst_ni = 1'b1;
    repeat (13) tick();
    chk("relock_soc_pre", 32'(soc_rst_no), 32'd0);
    clk_locked_i = 1'b0;
    repeat (3) tick();
    clk_locked_i = 1'b1;
    lows = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (soc_rst_no !== 1'b0) lows++;
    end
    chk("relock_soc_held", 32'(lows), 32'd0);
    wait_soc(1'b1, 34, n);
    chk("relock_rise_edge", 32'(n), 32'd35);
    chk("relock_cause", 32'(rst_cause_o), 32'd0);
    chk("relock_jtag", 32'(jtag_trst_no), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/nexys_rst_gen.md
NEXYS_RST_GEN -- requirements
Module: nexys_rst_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100000, the number of stable button cycles needed to accept a level change (1 ms at 100 MHz).
REQ-002 SHALL have parameter HOLD_CYCLES, default 1024, the minimum SoC reset hold time in cycles.
REQ-003 SHALL have port clk_i, input, 1 bit: board reference clock (output of sys_clk input buffer); the only clock.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low power-on reset.
REQ-005 SHALL have port btn_rst_ni, input, 1 bit: raw board reset button, asynchronous, low = pressed.
REQ-006 SHALL have port clk_locked_i, input, 1 bit: clock-source locked flag, asynchronous, high = stable.
REQ-007 SHALL have port soc_rst_no, output, 1 bit: conditioned SoC reset driving pulpissimo pad_reset_n; low = reset.
REQ-008 SHALL have port jtag_trst_no, output, 1 bit: JTAG TAP reset driving pad_jtag_trst; low = reset.
REQ-009 SHALL have port rst_cause_o, output, 2 bits: cause of the last reset (00 POR, 01 button, 10 lock loss, 11 reserved).

Function
REQ-010 SHALL synchronise btn_rst_ni and clk_locked_i through two flops each, with reset values 1 and 0 respectively.
REQ-011 SHALL drive the debounced button btn_db: a counter increments while the synced button differs from btn_db and clears on a match; at DEBOUNCE_CYCLES-1, btn_db flips and the counter clears. btn_db resets to 1.
REQ-012 SHALL size all counters as $clog2 of the respective parameter, minimum 1 bit; counters SHALL saturate and never wrap.
REQ-013 SHALL implement FSM states WAIT_LOCK (reset state), HOLD, RUN and BTN.
REQ-014 In WAIT_LOCK, the FSM SHALL go to HOLD when lock_sync=1 and btn_db=1; otherwise it SHALL stay.
REQ-015 In HOLD, the hold counter SHALL start at 0 on entry and the FSM SHALL go to RUN after HOLD_CYCLES cycles in HOLD.
REQ-016 In HOLD, lock_sync=0 SHALL go to WAIT_LOCK and btn_db=0 SHALL go to BTN; either one restarts the hold time.
REQ-017 In RUN, lock_sync=0 SHALL go to WAIT_LOCK and set rst_cause_o=10; btn_db=0 SHALL go to BTN and set rst_cause_o=01.
REQ-018 In BTN, the FSM SHALL go to WAIT_LOCK on lock_sync=0, else to HOLD on btn_db=1.
REQ-019 On simultaneous lock loss and button press, lock loss SHALL take priority (WAIT_LOCK, cause 10).
REQ-020 soc_rst_no SHALL be registered and SHALL be 1 exactly when the FSM state is RUN, updated on the same edge as the state.
REQ-021 jtag_trst_no SHALL be registered, 0 from rst_ni until the first entry to RUN, then 1 until the next rst_ni; button and lock loss SHALL NOT reassert it.
REQ-022 rst_cause_o SHALL hold its value until the next cause event; it SHALL change only on a transition out of RUN.
REQ-023 All outputs SHALL be glitch-free flop outputs; there SHALL be no combinational path from any input to any output.

Reset
REQ-024 On rst_ni=0, the block SHALL asynchronously force state=WAIT_LOCK, soc_rst_no=0, jtag_trst_no=0, rst_cause_o=00, and all counters=0.
REQ-025 rst_ni SHALL be deasserted synchronously to clk_i by the upstream driver; the block SHALL NOT resynchronise it.
REQ-026 Assertion of rst_ni in any state, including mid-HOLD, SHALL abort the operation with no residual count.

Configuration
REQ-027 Macro NEXYS_RST_DEBOUNCE_EN defined: the debounce filter of REQ-011 SHALL be compiled in.
REQ-028 Macro NEXYS_RST_DEBOUNCE_EN undefined: btn_db SHALL equal the synced button directly, DEBOUNCE_CYCLES SHALL be ignored, and no debounce counter SHALL exist.

Verification (bench: DEBOUNCE_CYCLES=8, HOLD_CYCLES=16)
REQ-029 POR: rst_ni low 5 cycles, then high; clk_locked_i=1 and btn_rst_ni=1 throughout -> soc_rst_no and jtag_trst_no rise on the 19th rising edge after release; rst_cause_o=00.
REQ-030 Glitch: in RUN, btn_rst_ni low for 5 cycles -> with the macro, no change on any output; without the macro, soc_rst_no low, then high 16+ cycles after release, with rst_cause_o=01.
REQ-031 Press: in RUN, btn_rst_ni low for 40 cycles (macro on) -> soc_rst_no falls 11 cycles after the press; rst_cause_o=01; jtag_trst_no stays 1; soc_rst_no rises 8+16+3 cycles after the release.
REQ-032 Simultaneous: in RUN, clk_locked_i and btn_rst_ni fall on the same edge -> soc_rst_no=0, state WAIT_LOCK, rst_cause_o=10.
REQ-033 Relock in HOLD: clk_locked_i low 3 cycles at hold count 10 -> soc_rst_no remains 0 for a full 16 HOLD cycles after relock.
REQ-034 Async reset: rst_ni pulled low mid-RUN, between edges -> soc_rst_no=0, jtag_trst_no=0 and rst_cause_o=00 immediately, without a clock edge.
